stopwatch_ctrl: RTL and testbench

- Sequencing controller for the 4-digit multiplexed seven-segment stopwatch.
- Conditions three push-buttons (start/stop, lap, clear) and runs a run/pause/lap state machine.
- Maintains a BCD centisecond count SS.cc from 00.00 to 99.99.
- Drives the 16-bit packed-digit bus consumed by the display scan driver; digit[3:0] is the rightmost digit.

---
 rtl/stopwatch_pkg.sv | 17 +
 rtl/btn_debounce.sv | 51 +++++
 rtl/stopwatch_ctrl.sv | 172 +++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } state_t;

    localparam int          BCD_DIGITS = 4;
    localparam logic [3:0]  BCD_MAX    = 4'd9;
    localparam logic [15:0] BCD_SAT    = 16'h9999;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stable-level counter, one-cycle press pulse.
// Latency: pulse appears 2 + DEBOUNCE_CYCLES clocks after a clean raw rising level.
// Backpressure: none; a held button gives exactly one pulse, release gives none.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          meta;
    logic          sync;
    logic          level;
    logic [CW-1:0] cnt;

    // Two-stage synchronizer for the asynchronous raw button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= btn;
            sync <= meta;
        end
    end

    // Accept a new level only after an unbroken run of differing samples; pulse on accepted rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt   <= '0;
                level <= sync;
                press <= sync;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: debounced buttons drive an IDLE/RUN/PAUSE/LAP FSM over a BCD SS.cc count.
// Latency: state changes one clock after a press pulse; digit/running/lap_active lag one more clock.
// Backpressure: none; illegal or lower-priority presses in a cycle are dropped.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ          = 50_000_000,
    parameter int TICK_HZ         = 100,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_start_stop,
    input  logic        btn_lap,
    input  logic        btn_clear,
    output logic [15:0] digit,
    output logic        running,
    output logic        lap_active,
    output logic        overflow
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] presc;
    logic [15:0]   count;
    logic [15:0]   count_inc;
    logic [15:0]   snapshot;
    logic          inc_carry;

    logic          ss_p;
    logic          lap_p;
    logic          clr_p;
    logic          counting;
    logic          tick;
    logic          saturate;
    logic          do_clear;
    logic          take_lap;

    logic          running_d;
    logic          lap_active_d;
    logic [15:0]   digit_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_start_stop),
        .press (ss_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_lap),
        .press (lap_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_clear),
        .press (clr_p)
    );

    assign counting = (state == ST_RUN) || (state == ST_LAP);
    assign tick     = counting && (presc == PW'(DIV - 1));
    // A tick at full scale pins the count and forces PAUSE ahead of any button.
    assign saturate = tick && (count == BCD_SAT);
    assign do_clear = (state == ST_PAUSE) && clr_p;
    assign take_lap = (state == ST_RUN) && !saturate && !ss_p && lap_p;

    // Cascaded BCD increment: each digit wraps 9->0 and carries into the next.
    always_comb begin
        count_inc = count;
        inc_carry = 1'b1;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (inc_carry) begin
                if (count[i*4 +: 4] == BCD_MAX) begin
                    count_inc[i*4 +: 4] = 4'd0;
                end else begin
                    count_inc[i*4 +: 4] = count[i*4 +: 4] + 4'd1;
                    inc_carry = 1'b0;
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: within each state clear beats start_stop beats lap, illegal presses dropped.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (ss_p) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (saturate || ss_p) state_nxt = ST_PAUSE;
                else if (lap_p)       state_nxt = ST_LAP;
            end
            ST_LAP: begin
                if (saturate || ss_p) state_nxt = ST_PAUSE;
                else if (lap_p)       state_nxt = ST_RUN;
            end
            ST_PAUSE: begin
                if (clr_p)                  state_nxt = ST_IDLE;
                else if (ss_p && !overflow) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM output decode feeding the registered display and status outputs.
    always_comb begin
        running_d    = counting;
        lap_active_d = (state == ST_LAP);
        digit_d      = (state == ST_LAP) ? snapshot : count;
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running    <= 1'b0;
            lap_active <= 1'b0;
            digit      <= 16'h0000;
        end else begin
            running    <= running_d;
            lap_active <= lap_active_d;
            digit      <= digit_d;
        end
    end

    // Prescaler, live count, sticky overflow and lap snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc    <= '0;
            count    <= 16'h0000;
            overflow <= 1'b0;
            snapshot <= 16'h0000;
        end else begin
            if (do_clear) begin
                presc    <= '0;
                count    <= 16'h0000;
                overflow <= 1'b0;
            end else begin
                // Held in PAUSE so a resume continues mid-tick; zero in IDLE so a start is aligned.
                if (counting) begin
                    presc <= (presc == PW'(DIV - 1)) ? '0 : presc + PW'(1);
                end else if (state == ST_IDLE) begin
                    presc <= '0;
                end
                if (tick) begin
                    if (count == BCD_SAT) overflow <= 1'b1;
                    else                  count    <= count_inc;
                end
            end
            if (take_lap) begin
                snapshot <= count;
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: reset, counting/carry, bounce, lap, priority, saturation.
// Main instance ticks every 10 clocks; a second instance ticks every clock to reach 99.99 quickly.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_stopwatch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        btn_ss, btn_lap, btn_clr;
    logic [15:0] digit;
    logic        running, lap_active, overflow;

    logic        fbtn_ss, fbtn_lap, fbtn_clr;
    logic [15:0] fdigit;
    logic        frunning, flap_active, foverflow;

    int total = 0;
    int bad   = 0;
    logic seen_run;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100), .DEBOUNCE_CYCLES(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .btn_start_stop (btn_ss),
        .btn_lap        (btn_lap),
        .btn_clear      (btn_clr),
        .digit          (digit),
        .running        (running),
        .lap_active     (lap_active),
        .overflow       (overflow)
    );

    stopwatch_ctrl #(.CLK_HZ(100), .TICK_HZ(100), .DEBOUNCE_CYCLES(4)) dut_fast (
        .clk            (clk),
        .rst_n          (rst_n),
        .btn_start_stop (fbtn_ss),
        .btn_lap        (fbtn_lap),
        .btn_clear      (fbtn_clr),
        .digit          (fdigit),
        .running        (frunning),
        .lap_active     (flap_active),
        .overflow       (foverflow)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // m[0]=start_stop, m[1]=lap, m[2]=clear; held for n clocks then released.
    task automatic press(input logic [2:0] m, input int n);
        {btn_clr, btn_lap, btn_ss} = m;
        cyc(n);
        {btn_clr, btn_lap, btn_ss} = 3'b000;
    endtask

    task automatic fpress(input logic [2:0] m, input int n);
        {fbtn_clr, fbtn_lap, fbtn_ss} = m;
        cyc(n);
        {fbtn_clr, fbtn_lap, fbtn_ss} = 3'b000;
    endtask

    initial begin
        rst_n = 1'b0;
        {btn_clr, btn_lap, btn_ss}    = 3'b000;
        {fbtn_clr, fbtn_lap, fbtn_ss} = 3'b000;
        cyc(3);
        check("rst_digit",   digit, 16'h0000);
        check("rst_running", 16'(running), 16'h0000);
        check("rst_ovf",     16'(overflow), 16'h0000);
        check("rst_fdigit",  fdigit, 16'h0000);
        rst_n = 1'b1;

        // Idle: nothing moves, lap and clear do nothing.
        cyc(100);
        check("idle_digit",   digit, 16'h0000);
        check("idle_running", 16'(running), 16'h0000);
        check("idle_ovf",     16'(overflow), 16'h0000);
        press(3'b010, 8);
        cyc(10);
        press(3'b100, 8);
        cyc(10);
        check("idle_lapclr_digit",   digit, 16'h0000);
        check("idle_lapclr_running", 16'(running), 16'h0000);
        check("idle_lapclr_lap",     16'(lap_active), 16'h0000);

        // Start: pulse 6 clocks after press, RUN at 7, running at 8.
        press(3'b001, 8);                                   // now at N8
        check("start_running", 16'(running), 16'h0001);
        cyc(92);                                            // N100
        check("cnt_0009", digit, 16'h0009);
        cyc(10);                                            // N110
        check("cnt_0010_carry", digit, 16'h0010);
        cyc(898);                                           // N1008
        check("cnt_0100", digit, 16'h0100);

        // Lap at 01.23: snapshot frozen while the live count runs on.
        cyc(227);                                           // N1235
        press(3'b010, 8);                                   // N1243
        check("lap_enter_digit", digit, 16'h0123);
        check("lap_enter_flag",  16'(lap_active), 16'h0001);
        cyc(500);                                           // N1743
        check("lap_hold_digit",   digit, 16'h0123);
        check("lap_hold_running", 16'(running), 16'h0001);
        press(3'b010, 8);                                   // N1751
        check("lap_exit_digit",   digit, 16'h0174);
        check("lap_exit_flag",    16'(lap_active), 16'h0000);
        check("lap_exit_running", 16'(running), 16'h0001);

        // Clear in RUN is ignored.
        press(3'b100, 8);                                   // N1759
        cyc(20);                                            // N1779
        check("run_clr_running", 16'(running), 16'h0001);
        check("run_clr_digit",   digit, 16'h0177);

        // Pause at 02.00, then start_stop+clear together: clear wins.
        cyc(224);                                           // N2003
        press(3'b001, 8);                                   // N2011
        cyc(20);                                            // N2031
        check("pause_digit",   digit, 16'h0200);
        check("pause_running", 16'(running), 16'h0000);
        press(3'b101, 8);                                   // N2039
        check("prio_digit",   digit, 16'h0000);
        check("prio_running", 16'(running), 16'h0000);
        cyc(20);
        check("prio_stay_digit",   digit, 16'h0000);
        check("prio_stay_running", 16'(running), 16'h0000);

        // Bounce: 2-clock toggles never qualify; a steady hold gives a single start.
        seen_run = 1'b0;
        for (int k = 0; k < 5; k++) begin
            btn_ss = 1'b1;
            repeat (2) begin
                @(negedge clk);
                if (running) seen_run = 1'b1;
            end
            btn_ss = 1'b0;
            repeat (2) begin
                @(negedge clk);
                if (running) seen_run = 1'b1;
            end
        end
        check("bounce_no_start", 16'(seen_run), 16'h0000);
        press(3'b001, 10);                                  // M30
        check("bounce_start", 16'(running), 16'h0001);
        cyc(30);                                            // M60
        check("bounce_single", 16'(running), 16'h0001);
        press(3'b001, 3);                                   // 3-clock glitch
        cyc(20);                                            // M83
        check("glitch_running", 16'(running), 16'h0001);
        check("glitch_digit",   digit, 16'h0005);

        // Saturation on the fast instance: one tick per clock once running.
        fpress(3'b001, 8);                                  // F8
        check("f_start_running", 16'(frunning), 16'h0001);
        cyc(9998);                                          // F10006
        check("f_9998", fdigit, 16'h9998);
        cyc(4);                                             // F10010
        check("f_sat_digit",   fdigit, 16'h9999);
        check("f_sat_ovf",     16'(foverflow), 16'h0001);
        check("f_sat_running", 16'(frunning), 16'h0000);
        cyc(20);
        check("f_no_wrap", fdigit, 16'h9999);
        fpress(3'b001, 8);
        cyc(10);
        check("f_ss_ignored_running", 16'(frunning), 16'h0000);
        check("f_ss_ignored_digit",   fdigit, 16'h9999);
        check("f_ss_ignored_ovf",     16'(foverflow), 16'h0001);
        fpress(3'b100, 8);
        check("f_clr_digit",   fdigit, 16'h0000);
        check("f_clr_ovf",     16'(foverflow), 16'h0000);
        check("f_clr_running", 16'(frunning), 16'h0000);

        // Asynchronous reset while the main instance is running.
        check("pre_rst_running", 16'(running), 16'h0001);
        rst_n = 1'b0;
        #1;
        check("arst_digit",   digit, 16'h0000);
        check("arst_running", 16'(running), 16'h0000);
        check("arst_ovf",     16'(overflow), 16'h0000);
        check("arst_lap",     16'(lap_active), 16'h0000);
        cyc(3);
        rst_n = 1'b1;
        cyc(30);
        check("post_rst_digit",   digit, 16'h0000);
        check("post_rst_running", 16'(running), 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
